// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO owner and multi-cycle MUL/DIV engine.
//
// Runs an iterative shift-add multiplier and a restoring divider on operand
// magnitudes, then applies the two's-complement sign fix when writing HI/LO.
// One iteration per cycle, WIDTH iterations per operation.
//
// Optional build macro: MULDIV_ABORT_EN adds an 'abort' input that flushes an
// in-flight operation without touching HI/LO and without a done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; mthi/mtlo writes accepted here
// RUN   | one multiply/divide iteration per cycle, counter 0..WIDTH-1
// FIX   | sign correction, HI/LO written on the leaving edge, done follows

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic             readReq,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;    // mult: multiplicand magnitude; div: divisor magnitude
    logic               is_div_q;
    logic               neg_q;     // product sign (mult) or quotient sign (div)
    logic               neg_r_q;   // remainder sign, follows the dividend
    logic               div0_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               abort_hit;

`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Operand conditioning at issue: magnitudes for signed ops, raw for unsigned.
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & srcA[WIDTH-1];
        b_neg     = signed_op & srcB[WIDTH-1];
        a_mag     = a_neg ? (~srcA + 1'b1) : srcA;
        b_mag     = b_neg ? (~srcB + 1'b1) : srcB;
    end

    // One iteration of each algorithm; RUN picks by latched op class.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        trial    = rem_sh - {1'b0, opnd_q};
        if (trial[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction of the finished magnitudes.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        // A zero divisor yields an all-ones quotient whatever the signs.
        if (div0_q) begin
            quo_fix = {WIDTH{1'b1}};
        end else begin
            quo_fix = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        end
        // With a zero divisor the remainder is |srcA|, so this restores srcA exactly.
        rem_fix = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = IDLE;
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy  = (state_q == RUN) || (state_q == FIX);
        stall = busy || (readReq && busy) || (start && (state_q != IDLE));
    end

    // Datapath: operand latch, iteration, HI/LO writes and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q    <= '0;
                        is_div_q <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        if (op[1]) begin
                            acc_q   <= {{WIDTH{1'b0}}, a_mag};
                            opnd_q  <= b_mag;
                            neg_r_q <= a_neg;
                            div0_q  <= (srcB == '0);
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, b_mag};
                            opnd_q  <= a_mag;
                            neg_r_q <= 1'b0;
                            div0_q  <= 1'b0;
                        end
                    end else begin
                        if (hiWe) hi_q <= srcA;
                        if (loWe) lo_q <= srcA;
                    end
                end
                RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    if (!abort_hit) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32), expected values hand-computed.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hiWe;
    logic        loWe;
    logic        readReq;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .hiWe    (hiWe),
        .loWe    (loWe),
        .readReq (readReq),
`ifdef MULDIV_ABORT_EN
        .abort   (abort),
`endif
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and watch 40 edges: done once at edge 34, busy for 33 cycles.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
            end
        end
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, "_done_count"}, 64'(done_n), 64'd1);
        chk({tag, "_done_edge"}, 64'(done_at), 64'd34);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int done_n;
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;

        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        srcA    = '0;
        srcB    = '0;
        hiWe    = 1'b0;
        loWe    = 1'b0;
        readReq = 1'b0;
`ifdef MULDIV_ABORT_EN
        abort   = 1'b0;
`endif
        #12;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("multu",      2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",       2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_zero",  2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_zero",   2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // IDLE register writes.
        srcA = 32'h0000_ABCD; hiWe = 1'b1;
        tick();
        hiWe = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h0000_ABCD);
        chk("mthi_lo_kept", {32'd0, lo}, 64'h8000_0000);
        srcA = 32'h0000_1234; loWe = 1'b1;
        tick();
        loWe = 1'b0;
        chk("mtlo", {32'd0, lo}, 64'h0000_1234);
        srcA = 32'h5555_5555; hiWe = 1'b1; loWe = 1'b1;
        tick();
        hiWe = 1'b0; loWe = 1'b0;
        chk("mthilo_hi", {32'd0, hi}, 64'h5555_5555);
        chk("mthilo_lo", {32'd0, lo}, 64'h5555_5555);

        // readReq while idle does not stall.
        readReq = 1'b1;
        #1;
        chk("read_idle_stall", {63'd0, stall}, 64'd0);
        readReq = 1'b0;

        // start together with hiWe: start wins, write dropped.
        op = 2'b11; srcA = 32'd100; srcB = 32'd7; start = 1'b1; hiWe = 1'b1;
        tick();
        start = 1'b0; hiWe = 1'b0;
        chk("start_wins_busy", {63'd0, busy}, 64'd1);
        chk("start_wins_hi", {32'd0, hi}, 64'h5555_5555);
        for (int i = 0; i < 9; i++) tick();

        // Hazards mid-RUN: readReq, second start and mthi all present.
        readReq = 1'b1; start = 1'b1; op = 2'b01; srcA = 32'h0000_ABCD; srcB = 32'd3; hiWe = 1'b1;
        #1;
        chk("hz_stall", {63'd0, stall}, 64'd1);
        tick();
        chk("hz_hi_held", {32'd0, hi}, 64'h5555_5555);
        chk("hz_lo_held", {32'd0, lo}, 64'h5555_5555);
        for (int i = 0; i < 5; i++) tick();
        chk("hz_stall_late", {63'd0, stall}, 64'd1);
        chk("hz_hi_late", {32'd0, hi}, 64'h5555_5555);
        readReq = 1'b0; start = 1'b0; hiWe = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_n++;
        end
        chk("hz_done_once", 64'(done_n), 64'd1);
        chk("hz_lo", {32'd0, lo}, 64'd14);
        chk("hz_hi", {32'd0, hi}, 64'd2);
        chk("hz_no_second_op", {63'd0, busy}, 64'd0);

`ifdef MULDIV_ABORT_EN
        // Abort at step 10: back to IDLE next edge, HI/LO untouched, no done.
        keep_hi = hi;
        keep_lo = lo;
        op = 2'b01; srcA = 32'd7; srcB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, {32'd0, keep_hi});
        chk("abort_lo", {32'd0, lo}, {32'd0, keep_lo});
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_n++;
        end
        chk("abort_no_done", 64'(done_n), 64'd0);
`else
        keep_hi = '0;
        keep_lo = '0;
`endif

        // Reset at step 10 of a multiply.
        op = 2'b00; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        #1;
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_n++;
        end
        chk("midrst_no_done", 64'(done_n), 64'd0);
        chk("midrst_hi_after", {32'd0, hi}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
